// File: rtl/dma_mc_controller.sv
// dma_mc_controller: multi-channel DMA controller that arbitrates device requests and moves words between memory and the granted device.
// Ports:
//   clk_i, reset_i                      clock, asynchronous active-high reset
//   ch_rqst_i/ch_rd_wr_i/ch_prio_i      per-channel request, direction (1 = memory->device), priority
//   ch_start_addr_i/ch_num_words_i      packed per-channel start address and word count
//   dev_in_i/dev_strb_i/dev_out_o       device data in, device strobe, shared device data out
//   dma_strb_o/ch_ack_o/ch_end_o/ch_err_o  per-channel data strobe, grant, completion and error pulses
//   dma_in_i/dma_ready_i/dma_resp_i     memory read data, access complete, bus error
//   dma_addr_o/dma_out_o/dma_en_o/dma_we_o/dma_priority_o  memory request side
// Build option: define DMA_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module dma_mc_controller #(
    parameter int NUM_CH   = 4,
    parameter int ADD_LEN  = 16,
    parameter int DATA_LEN = 16,
    parameter int CNT_LEN  = 8,
    parameter int ADDR_INC = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_CH-1:0]            ch_rqst_i,
    input  logic [NUM_CH-1:0]            ch_rd_wr_i,
    input  logic [NUM_CH-1:0]            ch_prio_i,
    input  logic [NUM_CH*ADD_LEN-1:0]    ch_start_addr_i,
    input  logic [NUM_CH*CNT_LEN-1:0]    ch_num_words_i,
    input  logic [NUM_CH*DATA_LEN-1:0]   dev_in_i,
    input  logic [NUM_CH-1:0]            dev_strb_i,
    output logic [DATA_LEN-1:0]          dev_out_o,
    output logic [NUM_CH-1:0]            dma_strb_o,
    output logic [NUM_CH-1:0]            ch_ack_o,
    output logic [NUM_CH-1:0]            ch_end_o,
    output logic [NUM_CH-1:0]            ch_err_o,
    input  logic [DATA_LEN-1:0]          dma_in_i,
    input  logic                         dma_ready_i,
    input  logic                         dma_resp_i,
    output logic [ADD_LEN-1:0]           dma_addr_o,
    output logic [DATA_LEN-1:0]          dma_out_o,
    output logic                         dma_en_o,
    output logic [1:0]                   dma_we_o,
    output logic                         dma_priority_o
);
    localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, MEM_RD, DEV_TX, DEV_RX, MEM_WR, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       g_q, g_d, pick, start;
    logic                dir_q, dir_d;
    logic [ADD_LEN-1:0]  cur_q, cur_d, cur_inc;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d, done_q, done_d, done_inc;
    logic [DATA_LEN-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0]   g_oh;
    logic                strb_g, last;

`ifdef DMA_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    assign g_oh     = NUM_CH'(1) << g_q;
    assign strb_g   = dev_strb_i[g_q];
    assign cur_inc  = cur_q + ADD_LEN'(ADDR_INC);
    assign done_inc = done_q + CNT_LEN'(1);
    assign last     = done_inc == cnt_q;

    // Scan from the start channel with wrap; the loop runs downward so the
    // closest requester to the start position is the one left in pick.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_CH;
            if (ch_rqst_i[idx[GW-1:0]]) pick = idx[GW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        dir_d   = dir_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        hold_d  = hold_q;
`ifdef DMA_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: if (|ch_rqst_i) begin
                g_d     = pick;
                dir_d   = ch_rd_wr_i[pick];
                state_d = GRANT;
            end
            GRANT: begin
                cur_d   = ch_start_addr_i[int'(g_q)*ADD_LEN +: ADD_LEN];
                cnt_d   = ch_num_words_i[int'(g_q)*CNT_LEN +: CNT_LEN];
                done_d  = '0;
`ifdef DMA_ROUND_ROBIN_EN
                ptr_d   = (g_q == GW'(NUM_CH - 1)) ? '0 : g_q + GW'(1);
`endif
                state_d = (ch_num_words_i[int'(g_q)*CNT_LEN +: CNT_LEN] == '0) ? DONE :
                          dir_q ? MEM_RD : DEV_RX;
            end
            MEM_RD: if (dma_ready_i) begin
                hold_d  = dma_resp_i ? hold_q : dma_in_i;
                state_d = dma_resp_i ? ERR : DEV_TX;
            end
            DEV_TX: if (strb_g) begin
                cur_d   = cur_inc;
                done_d  = done_inc;
                state_d = last ? DONE : MEM_RD;
            end
            DEV_RX: if (strb_g) begin
                hold_d  = dev_in_i[int'(g_q)*DATA_LEN +: DATA_LEN];
                state_d = MEM_WR;
            end
            MEM_WR: if (dma_ready_i) begin
                cur_d   = dma_resp_i ? cur_q : cur_inc;
                done_d  = dma_resp_i ? done_q : done_inc;
                state_d = dma_resp_i ? ERR : last ? DONE : DEV_RX;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            dir_q   <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            hold_q  <= '0;
`ifdef DMA_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            dir_q   <= dir_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
`ifdef DMA_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Outputs decode the registered state; only the device-to-memory strobe
    // follows dev_strb combinationally so the device sees same-cycle acceptance.
    assign dma_en_o       = state_q == MEM_RD || state_q == MEM_WR;
    assign dma_we_o       = {2{state_q == MEM_WR}};
    assign dma_addr_o     = dma_en_o ? cur_q : '0;
    assign dma_out_o      = state_q == MEM_WR ? hold_q : '0;
    assign dev_out_o      = state_q == DEV_TX ? hold_q : '0;
    assign dma_priority_o = dma_en_o & ch_prio_i[g_q];
    assign ch_ack_o       = state_q == GRANT ? g_oh : '0;
    assign ch_end_o       = (state_q == DONE || state_q == ERR) ? g_oh : '0;
    assign ch_err_o       = state_q == ERR ? g_oh : '0;
    assign dma_strb_o     = (state_q == DEV_TX || (state_q == DEV_RX && strb_g)) ? g_oh : '0;
endmodule

// File: tb/tb_dma_mc_controller.sv
// tb_dma_mc_controller: self-checking bench with a transfer-level reference model for dma_mc_controller.
module tb_dma_mc_controller;
    localparam int N = 4, AL = 16, DL = 16, CL = 8;

    logic clk = 1'b0, reset = 1'b0;
    logic [N-1:0]    ch_rqst, ch_rd_wr, ch_prio, dev_strb, dma_strb, ch_ack, ch_end, ch_err;
    logic [N*AL-1:0] ch_start_addr;
    logic [N*CL-1:0] ch_num_words;
    logic [N*DL-1:0] dev_in;
    logic [DL-1:0]   dev_out, dma_in, dma_out;
    logic [AL-1:0]   dma_addr;
    logic            dma_ready, dma_resp, dma_en, dma_priority;
    logic [1:0]      dma_we;

    int checks = 0, failures = 0;
    logic [AL-1:0] st [N];
    int            cnt[N];
    bit            rd [N];
`ifdef DMA_ROUND_ROBIN_EN
    int rr_next = 0;
`endif

    typedef struct {
        int ch; bit rd; logic [AL-1:0] st; int cnt; int err_at; int wr; int ws; bit exp_err;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    dma_mc_controller #(.NUM_CH(N), .ADD_LEN(AL), .DATA_LEN(DL), .CNT_LEN(CL), .ADDR_INC(1)) dut (
        .clk_i(clk), .reset_i(reset), .ch_rqst_i(ch_rqst), .ch_rd_wr_i(ch_rd_wr), .ch_prio_i(ch_prio),
        .ch_start_addr_i(ch_start_addr), .ch_num_words_i(ch_num_words), .dev_in_i(dev_in),
        .dev_strb_i(dev_strb), .dev_out_o(dev_out), .dma_strb_o(dma_strb), .ch_ack_o(ch_ack),
        .ch_end_o(ch_end), .ch_err_o(ch_err), .dma_in_i(dma_in), .dma_ready_i(dma_ready),
        .dma_resp_i(dma_resp), .dma_addr_o(dma_addr), .dma_out_o(dma_out), .dma_en_o(dma_en),
        .dma_we_o(dma_we), .dma_priority_o(dma_priority)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        dma_ready = 1'b0;
        dma_resp  = 1'b0;
        dev_strb  = '0;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) begin
            ch_start_addr[i*AL +: AL] = st[i];
            ch_num_words[i*CL +: CL]  = CL'(cnt[i]);
            ch_rd_wr[i]               = rd[i];
        end
    endtask

    // Arbitration model: fixed priority takes the lowest requester; round-robin
    // takes the first requester at or after the channel following the last grant.
    function automatic int model_pick(input logic [N-1:0] m);
        int base, c;
`ifdef DMA_ROUND_ROBIN_EN
        base = rr_next;
`else
        base = 0;
`endif
        for (int k = 0; k < N; k++) begin
            c = (base + k) % N;
            if (m[c[1:0]]) return c;
        end
        return 0;
    endfunction

    task automatic note_grant(input int g);
`ifdef DMA_ROUND_ROBIN_EN
        rr_next = (g + 1) % N;
`else
        if (g < 0) $display("note: negative grant index");
`endif
    endtask

    task automatic model_reset();
`ifdef DMA_ROUND_ROBIN_EN
        rr_next = 0;
`endif
    endtask

    task automatic run_xfer(input logic [N-1:0] mask, input int err_at, input int wr, input int ws, input bit exp_err);
        int g, n, w;
        logic [AL-1:0] a;
        logic [DL-1:0] d;
        logic [N-1:0]  oh;
        logic          pg;
        apply_cfg();
        ch_prio = N'($urandom);
        g  = model_pick(mask);
        oh = N'(1) << g;
        pg = ch_prio[g[1:0]];
        step(); quiet(); ch_rqst = mask; #1;
        chk("idle_ack", 64'(ch_ack), 64'd0);
        step(); ch_rqst = '0; #1;
        chk("ack", 64'(ch_ack), 64'(oh));
        chk("ack_en", 64'(dma_en), 64'd0);
        note_grant(g);
        n = cnt[g];
        a = st[g];
        for (int i = 0; i < n; i++) begin
            d = DL'($urandom);
            if (rd[g]) begin
                w = wr < 0 ? $urandom_range(-wr, 0) : wr;
                for (int c = 0; c <= w; c++) begin
                    step();
                    dma_ready = c == w;
                    dma_resp  = c == w ? i == err_at : 1'($urandom);
                    dma_in    = c == w ? d : DL'($urandom);
                    dev_strb  = N'($urandom);
                    #1;
                    chk("rd_ctl", 64'({dma_en, dma_we, dma_priority}), 64'({1'b1, 2'b00, pg}));
                    chk("rd_addr", 64'(dma_addr), 64'(a));
                    chk("rd_strb", 64'(dma_strb), 64'd0);
                end
                if (i == err_at) break;
                w = ws < 0 ? $urandom_range(-ws, 0) : ws;
                for (int c = 0; c <= w; c++) begin
                    step();
                    dev_strb  = (N'($urandom) & ~oh) | (c == w ? oh : '0);
                    dma_ready = 1'($urandom);
                    dma_resp  = 1'($urandom);
                    #1;
                    chk("tx_data", 64'(dev_out), 64'(d));
                    chk("tx_strb", 64'(dma_strb), 64'(oh));
                    chk("tx_ctl", 64'({dma_en, dma_we, dma_priority}), 64'd0);
                end
            end else begin
                w = ws < 0 ? $urandom_range(-ws, 0) : ws;
                for (int c = 0; c <= w; c++) begin
                    step();
                    dev_strb  = (N'($urandom) & ~oh) | (c == w ? oh : '0);
                    for (int j = 0; j < N; j++) dev_in[j*DL +: DL] = DL'($urandom);
                    dev_in[g*DL +: DL] = d;
                    dma_ready = 1'($urandom);
                    dma_resp  = 1'($urandom);
                    #1;
                    chk("rx_strb", 64'(dma_strb), c == w ? 64'(oh) : 64'd0);
                    chk("rx_en", 64'(dma_en), 64'd0);
                end
                w = wr < 0 ? $urandom_range(-wr, 0) : wr;
                for (int c = 0; c <= w; c++) begin
                    step();
                    dev_strb  = N'($urandom);
                    dma_ready = c == w;
                    dma_resp  = c == w ? i == err_at : 1'($urandom);
                    #1;
                    chk("wr_ctl", 64'({dma_en, dma_we, dma_priority}), 64'({1'b1, 2'b11, pg}));
                    chk("wr_addr", 64'(dma_addr), 64'(a));
                    chk("wr_data", 64'(dma_out), 64'(d));
                    chk("wr_strb", 64'(dma_strb), 64'd0);
                end
                if (i == err_at) break;
            end
            a = a + AL'(1);
        end
        step(); quiet(); #1;
        chk("end", 64'(ch_end), 64'(oh));
        chk("err", 64'(ch_err), exp_err ? 64'(oh) : 64'd0);
        chk("end_en", 64'(dma_en), 64'd0);
        step(); #1;
        chk("post_end", 64'(ch_end | ch_err), 64'd0);
        chk("post_en", 64'(dma_en), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got[$], at[$];
        int g, e;
        tbl[0] = '{0, 1'b1, 16'h0200, 3, -1, 0, 0, 1'b0};
        tbl[1] = '{2, 1'b0, 16'h1000, 2, -1, 3, 0, 1'b0};
        tbl[2] = '{1, 1'b1, 16'h0400, 0, -1, 0, 0, 1'b0};
        tbl[3] = '{3, 1'b1, 16'hFFFF, 2, -1, 1, 1, 1'b0};
        tbl[4] = '{1, 1'b1, 16'h0300, 4,  1, 0, 0, 1'b1};
        tbl[5] = '{0, 1'b0, 16'hFFFE, 3,  2, 1, 2, 1'b1};
        tbl[6] = '{3, 1'b0, 16'hFFFF, 2, -1, -2, -2, 1'b0};

        ch_rqst = '0; ch_rd_wr = '0; ch_prio = '1; ch_start_addr = '1; ch_num_words = '1;
        dev_in = '1; dma_in = '1; quiet();
        reset = 1'b1;
        step(); step();
        chk("rst_ctl", 64'({dma_en, dma_we, dma_priority, dma_strb, ch_ack, ch_end, ch_err}), 64'd0);
        chk("rst_bus", 64'({dma_addr, dma_out, dev_out}), 64'd0);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < N; i++) begin
            st[i] = AL'(i * 16'h0100); cnt[i] = 1; rd[i] = 1'b1;
        end
        foreach (tbl[t]) begin
            st[tbl[t].ch]  = tbl[t].st;
            cnt[tbl[t].ch] = tbl[t].cnt;
            rd[tbl[t].ch]  = tbl[t].rd;
            run_xfer(N'(1) << tbl[t].ch, tbl[t].err_at, tbl[t].wr, tbl[t].ws, tbl[t].exp_err);
        end

        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(15, 1));
            for (int i = 0; i < N; i++) begin
                st[i] = AL'($urandom); cnt[i] = $urandom_range(4, 0); rd[i] = 1'($urandom);
            end
            g = model_pick(m);
            e = (cnt[g] > 0 && $urandom_range(3, 0) == 0) ? $urandom_range(cnt[g] - 1, 0) : -1;
            run_xfer(m, e, -2, -2, e >= 0);
        end

        reset = 1'b1; step(); reset = 1'b0; model_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        apply_cfg();
        ch_rqst = '1;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            step(); #1;
            if (ch_ack != '0) begin
                got.push_back($clog2(ch_ack));
                at.push_back(c);
            end
        end
        ch_rqst = '0;
        chk("arb_count", 64'(got.size()), 64'd5);
        foreach (got[k]) begin
            g = model_pick('1);
            note_grant(g);
            chk("arb_order", 64'(got[k]), 64'(g));
            if (k > 0) chk("arb_gap", 64'(at[k] - at[k-1]), 64'd3);
        end
        step(); step(); step();

        reset = 1'b1; step(); reset = 1'b0; model_reset();
        st[2] = 16'h4000; cnt[2] = 2; rd[2] = 1'b0;
        apply_cfg();
        step(); quiet(); ch_rqst = 4'b0100;
        step(); ch_rqst = '0;
        step(); dev_strb = 4'b0100;
        step(); dev_strb = '0; dma_ready = 1'b0; #1;
        chk("pre_rst_en", 64'({dma_en, dma_we, dma_addr}), 64'({1'b1, 2'b11, 16'h4000}));
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({dma_en, dma_we, dma_priority, dma_strb, ch_ack, ch_end, ch_err}), 64'd0);
        chk("rst_mid_bus", 64'({dma_addr, dma_out, dev_out}), 64'd0);
        step(); reset = 1'b0; model_reset();
        step(); #1;
        chk("rst_no_end", 64'({ch_end, ch_err, dma_en}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
